// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_pkg
//  Description : Shared opcodes, FSM state encodings and helpers for the
//                UART/ALU command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

    localparam int NB_OP_DFLT = 6;
    localparam int NB_STATE   = 6;

    localparam logic [NB_OP_DFLT-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DFLT-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DFLT-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DFLT-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DFLT-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DFLT-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DFLT-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DFLT-1:0] OP_SRL = 6'b000010;

    localparam logic [7:0] ERR_CODE_DFLT = 8'hEE;

    // One-hot encoding keeps each state decode to a single flop
    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE    = 6'b000001,
        ST_WAIT_B  = 6'b000010,
        ST_WAIT_OP = 6'b000100,
        ST_EXEC    = 6'b001000,
        ST_SEND    = 6'b010000,
        ST_WAIT_TX = 6'b100000
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_ctrl_if
//  Description : UART receive/transmit handshake and ALU operand/result bus
//                seen by the command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_alu_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) ();

    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_data_a;
    logic [NB_DATA-1:0] o_alu_data_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_err;

    // The sequencer itself
    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_err
    );

    // UART pair and ALU around the sequencer
    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_alu_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_timeout
//  Description : Inter-byte watchdog counter; flags expiry after
//                TIMEOUT_CLKS enabled clocks without a clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_timeout
    import uart_alu_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int c_nb_cnt = clog2(TIMEOUT_CLKS) + 1;

    generate
        if (TIMEOUT_CLKS == 0) begin : g_disabled
            logic r_cnt;
            logic w_unused;

            always_ff @(posedge clk) begin
                r_cnt <= 1'b0;
            end

            assign w_unused  = &{1'b0, r_cnt, i_rst, i_clear, i_enable};
            assign o_expired = 1'b0;
        end else begin : g_counter
            localparam logic [c_nb_cnt-1:0] c_last = c_nb_cnt'(TIMEOUT_CLKS - 1);

            logic [c_nb_cnt-1:0] r_cnt;

            // Saturates at the terminal count so a held enable cannot wrap
            always_ff @(posedge clk) begin
                if (i_rst || i_clear) begin
                    r_cnt <= '0;
                end else if (i_enable && (r_cnt != c_last)) begin
                    r_cnt <= r_cnt + c_nb_cnt'(1);
                end
            end

            assign o_expired = i_enable && (r_cnt == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_ctrl
//  Description : Collects operand A, operand B and opcode bytes from the UART,
//                drives the ALU and returns one result byte to the transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int                 NB_DATA      = 8,
    parameter int                 NB_OP        = NB_OP_DFLT,
    parameter int                 TIMEOUT_CLKS = 1000000,
    parameter logic [NB_DATA-1:0] ERR_CODE     = NB_DATA'(ERR_CODE_DFLT)
) (
    input  logic            clk,
    input  logic            i_rst,
    uart_alu_ctrl_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_DATA-1:0] r_alu_data_a;
    logic [NB_DATA-1:0] w_alu_data_a_next;
    logic [NB_DATA-1:0] r_alu_data_b;
    logic [NB_DATA-1:0] w_alu_data_b_next;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_OP-1:0]   w_alu_op_next;
    logic [NB_DATA-1:0] r_tx_data;
    logic [NB_DATA-1:0] w_tx_data_next;
    logic               r_err;
    logic               w_err_next;

    logic [NB_OP-1:0]   w_opcode;
    logic               w_op_valid;
    logic               w_tmr_enable;
    logic               w_tmr_clear;
    logic               w_tmr_expired;

    assign w_opcode = bus.i_rx_data[NB_OP-1:0];

    always_comb begin
        w_op_valid = 1'b0;
        case (w_opcode)
            NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
            NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL):
                w_op_valid = 1'b1;
            default:
                w_op_valid = 1'b0;
        endcase
    end

    // Any received byte, or leaving the wait states, restarts the window
    assign w_tmr_enable = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_tmr_clear  = bus.i_rx_done || !w_tmr_enable;

    uart_alu_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_alu_data_a <= '0;
            r_alu_data_b <= '0;
            r_alu_op     <= '0;
            r_tx_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_alu_data_a <= w_alu_data_a_next;
            r_alu_data_b <= w_alu_data_b_next;
            r_alu_op     <= w_alu_op_next;
            r_tx_data    <= w_tx_data_next;
            r_err        <= w_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_alu_data_a_next = r_alu_data_a;
        w_alu_data_b_next = r_alu_data_b;
        w_alu_op_next     = r_alu_op;
        w_tx_data_next    = r_tx_data;
        w_err_next        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_rx_done) begin
                    w_alu_data_a_next = bus.i_rx_data;
                    w_state_next      = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_done) begin
                    w_alu_data_b_next = bus.i_rx_data;
                    w_state_next      = ST_WAIT_OP;
                end else if (w_tmr_expired) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    if (w_op_valid) begin
                        w_alu_op_next = w_opcode;
                        w_state_next  = ST_EXEC;
                    end else begin
                        // Skip EXEC: the error byte goes out in place of a result
                        w_tx_data_next = ERR_CODE;
                        w_err_next     = 1'b1;
                        w_state_next   = ST_SEND;
                    end
                end else if (w_tmr_expired) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_tx_data_next = bus.i_alu_result;
                w_state_next   = ST_SEND;
            end
            ST_SEND: begin
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.o_alu_data_a = r_alu_data_a;
    assign bus.o_alu_data_b = r_alu_data_b;
    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_tx_data    = r_tx_data;
    assign bus.o_tx_start   = (r_state == ST_SEND);
    assign bus.o_busy       = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                              (r_state == ST_WAIT_TX);
    assign bus.o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu_ctrl
//  Description : Directed self-checking bench for uart_alu_ctrl with a small
//                behavioural ALU closing the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_alu_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_ctrl #(
        .NB_DATA      (8),
        .NB_OP        (6),
        .TIMEOUT_CLKS (20),
        .ERR_CODE     (8'hEE)
    ) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (bus.o_alu_op)
            6'b100000: bus.i_alu_result = bus.o_alu_data_a + bus.o_alu_data_b;
            6'b100010: bus.i_alu_result = bus.o_alu_data_a - bus.o_alu_data_b;
            6'b100100: bus.i_alu_result = bus.o_alu_data_a & bus.o_alu_data_b;
            6'b100101: bus.i_alu_result = bus.o_alu_data_a | bus.o_alu_data_b;
            6'b100110: bus.i_alu_result = bus.o_alu_data_a ^ bus.o_alu_data_b;
            6'b100111: bus.i_alu_result = ~(bus.o_alu_data_a | bus.o_alu_data_b);
            6'b000011: bus.i_alu_result = 8'($signed(bus.o_alu_data_a) >>> bus.o_alu_data_b);
            6'b000010: bus.i_alu_result = bus.o_alu_data_a >> bus.o_alu_data_b;
            default:   bus.i_alu_result = 8'h00;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
    endtask

    // Called right after the opcode byte; n is cycles until o_tx_start
    task automatic wait_start(output int n);
        n = 1;
        while (bus.o_tx_start !== 1'b1 && n < 10) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data} !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h expected 0", {bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data});
        end
        vectors++;
        if ({bus.o_tx_start, bus.o_busy, bus.o_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.o_tx_start, bus.o_busy, bus.o_err});
        end
    endtask

    task automatic test_add();
        int n;
        send_cmd(8'h05, 8'h03, 8'h20);
        wait_start(n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL add_latency: got %0d expected 2", n);
        end
        vectors++;
        if (bus.o_alu_op !== 6'b100000) begin
            miscompares++;
            $display("FAIL add_op: got %b expected 100000", bus.o_alu_op);
        end
        vectors++;
        if (bus.o_tx_data !== 8'h08 || bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL add_data: got %h/%b expected 08/1", bus.o_tx_data, bus.o_busy);
        end
        step();
        vectors++;
        if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h08) begin
            miscompares++;
            $display("FAIL add_hold: got start=%b data=%h expected 0/08", bus.o_tx_start, bus.o_tx_data);
        end
        pulse_tx_done();
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL add_idle: got busy=%b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_ops_table();
        logic [7:0] tbl [6][4];
        int n;
        tbl = '{'{8'h0F, 8'h30, 8'h27, 8'hC0},
                '{8'h80, 8'h03, 8'h02, 8'h10},
                '{8'hAA, 8'h0F, 8'h24, 8'h0A},
                '{8'hA0, 8'h05, 8'h25, 8'hA5},
                '{8'h10, 8'h01, 8'h22, 8'h0F},
                '{8'h7F, 8'h01, 8'h20, 8'h80}};
        for (int i = 0; i < 6; i++) begin
            send_cmd(tbl[i][0], tbl[i][1], tbl[i][2]);
            wait_start(n);
            vectors++;
            if (n !== 2 || bus.o_tx_data !== tbl[i][3]) begin
                miscompares++;
                $display("FAIL ops_%0d: got lat=%0d data=%h expected 2/%h", i, n, bus.o_tx_data, tbl[i][3]);
            end
            step();
            pulse_tx_done();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        send_cmd(8'hF0, 8'h02, 8'h03);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'hFC) begin
            miscompares++;
            $display("FAIL b2b_sra: got lat=%0d data=%h expected 2/fc", n, bus.o_tx_data);
        end
        step();
        pulse_tx_done();
        send_cmd(8'h0F, 8'h0F, 8'h26);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h00 || bus.o_alu_op !== 6'b100110) begin
            miscompares++;
            $display("FAIL b2b_xor: got lat=%0d data=%h op=%b expected 2/00/100110", n, bus.o_tx_data, bus.o_alu_op);
        end
        step();
        pulse_tx_done();
        vectors++;
        if (bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_invalid();
        int starts;
        int errs;
        send_cmd(8'h01, 8'h02, 8'h3F);
        vectors++;
        if (bus.o_tx_start !== 1'b1 || bus.o_err !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_start_err: got start=%b err=%b expected 1/1", bus.o_tx_start, bus.o_err);
        end
        vectors++;
        if (bus.o_tx_data !== 8'hEE) begin
            miscompares++;
            $display("FAIL inv_data: got %h expected ee", bus.o_tx_data);
        end
        vectors++;
        if (bus.o_alu_op !== 6'b100110) begin
            miscompares++;
            $display("FAIL inv_op_kept: got %b expected 100110", bus.o_alu_op);
        end
        starts = 0;
        errs   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            starts += int'(bus.o_tx_start);
            errs   += int'(bus.o_err);
        end
        vectors++;
        if (starts !== 0 || errs !== 0 || bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_once: got extra starts=%0d errs=%0d busy=%b expected 0/0/1", starts, errs, bus.o_busy);
        end
        pulse_tx_done();
    endtask

    task automatic test_upper_bits();
        int n;
        send_cmd(8'h01, 8'h02, 8'hE0);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h03 || bus.o_alu_op !== 6'b100000) begin
            miscompares++;
            $display("FAIL upper_bits: got lat=%0d data=%h op=%b expected 2/03/100000", n, bus.o_tx_data, bus.o_alu_op);
        end
        step();
        pulse_tx_done();
    endtask

    task automatic test_timeout();
        int n;
        int errs;
        send_byte(8'h11);
        n = 0;
        while (bus.o_err !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 20) begin
            miscompares++;
            $display("FAIL timeout_cycles: got %0d expected 20", n);
        end
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 || bus.o_alu_data_a !== 8'h11) begin
            miscompares++;
            $display("FAIL timeout_state: got busy=%b start=%b a=%h expected 0/0/11", bus.o_busy, bus.o_tx_start, bus.o_alu_data_a);
        end
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            errs += int'(bus.o_err) + int'(bus.o_tx_start);
        end
        vectors++;
        if (errs !== 0) begin
            miscompares++;
            $display("FAIL timeout_once: got %0d extra err/start cycles expected 0", errs);
        end
        send_cmd(8'h02, 8'h02, 8'h22);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL timeout_next: got lat=%0d data=%h expected 2/00", n, bus.o_tx_data);
        end
        step();
        pulse_tx_done();
    endtask

    task automatic test_timeout_race();
        int n;
        send_byte(8'h33);
        for (int i = 0; i < 19; i++) step();
        vectors++;
        if (bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL race_early: got err=%b expected 0", bus.o_err);
        end
        send_byte(8'h44);
        vectors++;
        if (bus.o_err !== 1'b0 || bus.o_alu_data_b !== 8'h44) begin
            miscompares++;
            $display("FAIL race_byte_wins: got err=%b b=%h expected 0/44", bus.o_err, bus.o_alu_data_b);
        end
        send_byte(8'h20);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h77) begin
            miscompares++;
            $display("FAIL race_result: got lat=%0d data=%h expected 2/77", n, bus.o_tx_data);
        end
        step();
        pulse_tx_done();
    endtask

    task automatic test_spurious();
        int n;
        int bad;
        send_cmd(8'h05, 8'h03, 8'h20);
        send_byte(8'hAA);
        vectors++;
        if (bus.o_tx_start !== 1'b1 || bus.o_alu_data_a !== 8'h05) begin
            miscompares++;
            $display("FAIL spur_exec: got start=%b a=%h expected 1/05", bus.o_tx_start, bus.o_alu_data_a);
        end
        step();
        send_byte(8'hBB);
        vectors++;
        if (bus.o_alu_data_a !== 8'h05 || bus.o_alu_data_b !== 8'h03 || bus.o_tx_data !== 8'h08 ||
            bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_wait_tx: got a=%h b=%h data=%h busy=%b start=%b expected 05/03/08/1/0",
                     bus.o_alu_data_a, bus.o_alu_data_b, bus.o_tx_data, bus.o_busy, bus.o_tx_start);
        end
        pulse_tx_done();
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            pulse_tx_done();
            bad += int'(bus.o_busy) + int'(bus.o_tx_start);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL spur_tx_done_idle: got %0d busy/start cycles expected 0", bad);
        end
        send_cmd(8'h07, 8'h02, 8'h22);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h05) begin
            miscompares++;
            $display("FAIL spur_next: got lat=%0d data=%h expected 2/05", n, bus.o_tx_data);
        end
        step();
        pulse_tx_done();
    endtask

    task automatic test_reset_mid();
        int n;
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data,
             bus.o_tx_start, bus.o_busy, bus.o_err} !== 33'h0) begin
            miscompares++;
            $display("FAIL rst_wait_op: got a=%h b=%h op=%b data=%h ctrl=%b expected all 0", bus.o_alu_data_a,
                     bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data, {bus.o_tx_start, bus.o_busy, bus.o_err});
        end
        send_cmd(8'h0F, 8'h0C, 8'h24);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h0C) begin
            miscompares++;
            $display("FAIL rst_and: got lat=%0d data=%h expected 2/0c", n, bus.o_tx_data);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data,
             bus.o_tx_start, bus.o_busy, bus.o_err} !== 33'h0) begin
            miscompares++;
            $display("FAIL rst_wait_tx: got a=%h b=%h op=%b data=%h ctrl=%b expected all 0", bus.o_alu_data_a,
                     bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data, {bus.o_tx_start, bus.o_busy, bus.o_err});
        end
        send_cmd(8'h0A, 8'h05, 8'h25);
        wait_start(n);
        vectors++;
        if (n !== 2 || bus.o_tx_data !== 8'h0F) begin
            miscompares++;
            $display("FAIL rst_or: got lat=%0d data=%h expected 2/0f", n, bus.o_tx_data);
        end
        step();
        pulse_tx_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;

        test_reset();
        test_add();
        test_ops_table();
        test_back_to_back();
        test_invalid();
        test_upper_bits();
        test_timeout();
        test_timeout_race();
        test_spurious();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
